// File: rtl/sd_pkg.sv
// Shared SD data-line definitions: FSM states, error codes, CRC-status tokens
// and the serial CRC16 step used by both the block writer and the file reader.
package sd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_TOKEN,
    S_BUSY,
    S_RELEASE,
    S_FIN
  } state_t;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_UNDERRUN  = 3'd1;
  localparam logic [2:0] ERR_TOKEN_TMO = 3'd2;
  localparam logic [2:0] ERR_CRC       = 3'd3;
  localparam logic [2:0] ERR_WRITE     = 3'd4;
  localparam logic [2:0] ERR_BUSY_TMO  = 3'd5;
  localparam logic [2:0] ERR_BAD_TOKEN = 3'd6;

  localparam logic [2:0] TOK_OK    = 3'b010;
  localparam logic [2:0] TOK_CRC   = 3'b101;
  localparam logic [2:0] TOK_WRITE = 3'b110;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((b ^ crc[15]) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0), one bit per enabled clock.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit_in,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en)  r_crc <= crc16_step(r_crc, i_bit_in);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_dat_block_writer.sv
// SD DAT0 single-block writer: Nwr, start bit, block data, CRC16, end bit, then
// CRC-status token and busy collection. Everything is paced by the sd_fall/sd_rise strobes.
module sd_dat_block_writer
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT  = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sd_fall,
  input  logic       i_sd_rise,
  input  logic       i_start,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_byte,
  output logic       o_sddat0_out,
  output logic       o_sddat0_oe,
  input  logic       i_sddat0_in,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_err_code
);

  localparam int BCW = $clog2(BLOCK_BYTES) + 1;
  localparam logic [BCW-1:0] LP_BYTES = BCW'(BLOCK_BYTES);
  localparam logic [20:0]    TOK_LIM  = 21'(TOKEN_TIMEOUT - 1);
  localparam logic [20:0]    BUSY_LIM = 21'(BUSY_TIMEOUT - 1);

  state_t         r_state, w_state_nx;
  logic           r_oe, w_oe_nx, r_out, w_out_nx;
  logic           r_busy, w_busy_nx, r_done, w_done_nx;
  logic [2:0]     r_err, w_err_nx;
  logic [7:0]     r_shift, w_shift_nx, r_buf;
  logic           r_buf_full;
  logic [2:0]     r_bit_cnt, w_bit_cnt_nx, r_sub, w_sub_nx, r_tok, w_tok_nx;
  logic [BCW-1:0] r_byte_cnt, w_byte_cnt_nx;
  logic [20:0]    r_tmo, w_tmo_nx, w_tmo_inc;
  logic [3:0]     r_crc_idx, w_crc_idx_nx;
  logic           w_reload, w_start_ok, w_accept;
  logic           w_crc_en, w_crc_bit;
  logic [15:0]    w_crc;

  sd_crc16 u_crc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_ok),
    .i_en    (w_crc_en),
    .i_bit_in(w_crc_bit),
    .o_crc   (w_crc)
  );

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_tmo_inc  = (&r_tmo) ? r_tmo : r_tmo + 21'd1;
  assign o_in_ready = r_busy && !r_buf_full && (r_byte_cnt != LP_BYTES) &&
                      (r_state inside {S_PRE, S_START, S_DATA});
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_state_nx    = r_state;
    w_oe_nx       = r_oe;
    w_out_nx      = r_out;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_err_nx      = r_err;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_byte_cnt_nx = r_byte_cnt;
    w_sub_nx      = r_sub;
    w_tok_nx      = r_tok;
    w_tmo_nx      = r_tmo;
    w_crc_idx_nx  = r_crc_idx;
    w_reload      = 1'b0;
    w_crc_en      = 1'b0;
    w_crc_bit     = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nx    = S_PRE;
        w_busy_nx     = 1'b1;
        w_err_nx      = ERR_OK;
        w_byte_cnt_nx = '0;
        w_sub_nx      = '0;
      end
      S_PRE: if (i_sd_fall) begin
        w_oe_nx = 1'b1;
        if (r_sub == 3'd2) begin
          w_out_nx   = 1'b0;
          w_state_nx = S_START;
        end else begin
          w_out_nx = 1'b1;
          w_sub_nx = r_sub + 3'd1;
        end
      end
      S_START: if (i_sd_fall) begin
        if (r_buf_full) begin
          w_reload   = 1'b1;
          w_state_nx = S_DATA;
        end else begin
          w_out_nx   = 1'b1;
          w_err_nx   = ERR_UNDERRUN;
          w_state_nx = S_RELEASE;
        end
      end
      S_DATA: if (i_sd_fall) begin
        if (r_bit_cnt != 3'd7) begin
          w_shift_nx   = {r_shift[6:0], 1'b0};
          w_out_nx     = r_shift[6];
          w_bit_cnt_nx = r_bit_cnt + 3'd1;
          w_crc_en     = 1'b1;
          w_crc_bit    = r_shift[6];
        end else if (r_byte_cnt == LP_BYTES) begin
          w_out_nx     = w_crc[15];
          w_crc_idx_nx = '0;
          w_state_nx   = S_CRC;
        end else if (r_buf_full) begin
          w_reload = 1'b1;
        end else begin
          w_out_nx   = 1'b1;
          w_err_nx   = ERR_UNDERRUN;
          w_state_nx = S_RELEASE;
        end
      end
      S_CRC: if (i_sd_fall) begin
        if (r_crc_idx == 4'd15) begin
          w_out_nx   = 1'b1;
          w_state_nx = S_END;
        end else begin
          w_out_nx     = w_crc[4'd14 - r_crc_idx];
          w_crc_idx_nx = r_crc_idx + 4'd1;
        end
      end
      S_END: if (i_sd_fall) begin
        w_oe_nx    = 1'b0;
        w_sub_nx   = '0;
        w_tmo_nx   = '0;
        w_state_nx = S_TOKEN;
      end
      // sub 0-1: turnaround skip, 2: hunt start bit, 3-5: status bits, 6: end bit
      S_TOKEN: if (i_sd_rise) begin
        if (r_sub < 3'd2) begin
          w_sub_nx = r_sub + 3'd1;
        end else if (r_sub == 3'd2) begin
          if (!i_sddat0_in) w_sub_nx = 3'd3;
          else if (r_tmo == TOK_LIM) begin
            w_err_nx   = ERR_TOKEN_TMO;
            w_state_nx = S_FIN;
          end else w_tmo_nx = w_tmo_inc;
        end else if (r_sub != 3'd6) begin
          w_tok_nx = {r_tok[1:0], i_sddat0_in};
          w_sub_nx = r_sub + 3'd1;
        end else begin
          w_state_nx = S_FIN;
          if (!i_sddat0_in) w_err_nx = ERR_BAD_TOKEN;
          else begin
            case (r_tok)
              TOK_OK: begin
                w_state_nx = S_BUSY;
                w_tmo_nx   = '0;
              end
              TOK_CRC:   w_err_nx = ERR_CRC;
              TOK_WRITE: w_err_nx = ERR_WRITE;
              default:   w_err_nx = ERR_BAD_TOKEN;
            endcase
          end
        end
      end
      S_BUSY: if (i_sd_rise) begin
        if (i_sddat0_in) w_state_nx = S_FIN;
        else if (r_tmo == BUSY_LIM) begin
          w_err_nx   = ERR_BUSY_TMO;
          w_state_nx = S_FIN;
        end else w_tmo_nx = w_tmo_inc;
      end
      S_RELEASE: if (i_sd_fall) begin
        w_oe_nx    = 1'b0;
        w_out_nx   = 1'b1;
        w_state_nx = S_FIN;
      end
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (w_reload) begin
      w_shift_nx    = r_buf;
      w_out_nx      = r_buf[7];
      w_bit_cnt_nx  = '0;
      w_byte_cnt_nx = r_byte_cnt + 1'b1;
      w_crc_en      = 1'b1;
      w_crc_bit     = r_buf[7];
    end
    if (w_state_nx == S_FIN && r_state != S_FIN) begin
      w_busy_nx = 1'b0;
      w_done_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_oe       <= 1'b0;
      r_out      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_OK;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_sub      <= '0;
      r_tok      <= '0;
      r_tmo      <= '0;
      r_crc_idx  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_oe       <= w_oe_nx;
      r_out      <= w_out_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_byte_cnt <= w_byte_cnt_nx;
      r_sub      <= w_sub_nx;
      r_tok      <= w_tok_nx;
      r_tmo      <= w_tmo_nx;
      r_crc_idx  <= w_crc_idx_nx;
    end
  end

  // A reload frees the buffer in the same cycle a new byte may land in it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_accept) r_buf <= i_in_byte;
      if (w_start_ok) r_buf_full <= 1'b0;
      else            r_buf_full <= (r_buf_full && !w_reload) || w_accept;
    end
  end

  assign o_sddat0_out = r_out;
  assign o_sddat0_oe  = r_oe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err_code   = r_err;

endmodule

// File: tb/tb_sd_dat_block_writer.sv
// Directed bench for sd_dat_block_writer: byte source, DAT0 line capture and a
// scripted card answering with CRC-status tokens and busy.
module tb_sd_dat_block_writer;

  localparam int BB    = 512;
  localparam int TT    = 64;
  localparam int BT    = 100;
  localparam int NBITS = 3 + BB * 8 + 16 + 1;

  logic       i_clk, i_rst, i_sd_fall, i_sd_rise, i_start, i_in_valid;
  logic       o_in_ready, o_sddat0_out, o_sddat0_oe, i_sddat0_in, o_busy, o_done;
  logic [7:0] i_in_byte;
  logic [2:0] o_err_code;

  int   errors = 0;
  int   checks = 0;
  logic cap [0:32767];
  int   cap_n = 0;
  int   src_idx = 0;
  int   src_lim = 0;
  int   src_mode = 0;
  logic src_on = 1'b0;
  logic ph;

  sd_dat_block_writer #(.BLOCK_BYTES(BB), .TOKEN_TIMEOUT(TT), .BUSY_TIMEOUT(BT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sd_fall(i_sd_fall), .i_sd_rise(i_sd_rise),
    .i_start(i_start), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_byte(i_in_byte),
    .o_sddat0_out(o_sddat0_out), .o_sddat0_oe(o_sddat0_oe), .i_sddat0_in(i_sddat0_in),
    .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // sd_fall and sd_rise alternate, one strobe per system clock
  initial begin
    i_sd_fall = 1'b0; i_sd_rise = 1'b0; ph = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_sd_fall = ~ph; i_sd_rise = ph; ph = ~ph;
    end
  end

  function automatic logic [7:0] pat(input int mode, input int idx);
    logic [31:0] v;
    case (mode)
      0:       v = 32'hFF;
      1:       v = idx;
      default: v = idx * 7 + 3;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  initial begin
    logic take;
    i_in_valid = 1'b0; i_in_byte = 8'h00;
    forever begin
      @(negedge i_clk);
      take = i_in_valid && o_in_ready;
      @(posedge i_clk); #1;
      if (!src_on) src_idx = 0;
      else if (take) src_idx++;
      i_in_valid = src_on && (src_idx < src_lim);
      i_in_byte  = pat(src_mode, src_idx);
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_sd_rise && o_sddat0_oe && cap_n < 32768) begin
        cap[cap_n] = o_sddat0_out;
        cap_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic begin_block(input int mode, input int lim, output int base);
    src_on = 1'b0; tick(); tick();
    src_mode = mode; src_lim = lim; src_on = 1'b1; tick();
    base = cap_n;
    pulse_start();
  endtask

  task automatic wait_oe(input logic val, input int max, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge i_clk);
      ok = (o_sddat0_oe === val);
    end
  endtask

  task automatic wait_done(input int max, output logic ok, output int n);
    ok = o_done; n = 0;
    for (int k = 0; k < max && !ok; k++) begin
      @(posedge i_clk);
      if (i_sd_rise) n++;
      #1;
      ok = o_done;
    end
  endtask

  task automatic card_bit(input logic b);
    logic seen;
    i_sddat0_in = b;
    seen = 1'b0;
    while (!seen) begin
      @(posedge i_clk);
      seen = i_sd_rise;
      #1;
    end
  endtask

  task automatic card_token(input logic [2:0] t);
    card_bit(1'b1); card_bit(1'b1);
    check("oe_low_at_token", 32'(o_sddat0_oe), 32'd0);
    card_bit(1'b0);
    card_bit(t[2]); card_bit(t[1]); card_bit(t[0]);
    card_bit(1'b1);
  endtask

  function automatic logic [15:0] cap_crc(input int base);
    logic [15:0] v;
    for (int k = 0; k < 16; k++) v[15 - k] = cap[base + 3 + BB * 8 + k];
    return v;
  endfunction

  initial begin
    int   base, n, ones, bad;
    logic ok;
    logic [15:0] crc;
    logic [7:0]  b;
    i_rst = 1'b1; i_start = 1'b0; i_sddat0_in = 1'b1;
    repeat (3) tick();
    check("rst_oe", 32'(o_sddat0_oe), 32'd0);
    check("rst_out", 32'(o_sddat0_out), 32'd1);
    check("rst_ready", 32'(o_in_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err_code), 32'd0);
    i_rst = 1'b0; tick();

    // 1: asynchronous reset in the middle of the data phase
    begin_block(2, BB, base);
    ok = 1'b0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      tick();
      ok = (src_idx >= 100);
    end
    check("t1_reach_byte100", 32'(ok), 32'd1);
    check("t1_oe_before_rst", 32'(o_sddat0_oe), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("t1_oe_at_rst", 32'(o_sddat0_oe), 32'd0);
    check("t1_busy_at_rst", 32'(o_busy), 32'd0);
    check("t1_ready_at_rst", 32'(o_in_ready), 32'd0);
    src_on = 1'b0;
    tick(); tick();
    i_rst = 1'b0; tick();

    // 2: all-0xFF block, token 010, 10 SD clocks of busy
    begin_block(0, BB, base);
    wait_oe(1'b1, 50, ok);     check("t2_oe_up", 32'(ok), 32'd1);
    wait_oe(1'b0, 20000, ok);  check("t2_oe_down", 32'(ok), 32'd1);
    card_token(3'b010);
    for (int k = 0; k < 10; k++) card_bit(1'b0);
    i_sddat0_in = 1'b1;
    wait_done(100, ok, n);     check("t2_done", 32'(ok), 32'd1);
    check("t2_err", 32'(o_err_code), 32'd0);
    check("t2_busy_at_done", 32'(o_busy), 32'd0);
    check("t2_nbits", cap_n - base, NBITS);
    check("t2_nwr", {30'd0, cap[base], cap[base + 1]}, 32'd3);
    check("t2_startbit", 32'(cap[base + 2]), 32'd0);
    ones = 0;
    for (int k = 0; k < BB * 8; k++) if (cap[base + 3 + k] === 1'b1) ones++;
    check("t2_data_ones", ones, BB * 8);
    check("t2_crc", 32'(cap_crc(base)), 32'h7FA1);
    check("t2_endbit", 32'(cap[base + NBITS - 1]), 32'd1);
    tick();
    check("t2_done_one_clk", 32'(o_done), 32'd0);

    // 3: bytes 0..255 twice, card rejects CRC
    begin_block(1, BB, base);
    wait_oe(1'b1, 50, ok);     check("t3_oe_up", 32'(ok), 32'd1);
    wait_oe(1'b0, 20000, ok);  check("t3_oe_down", 32'(ok), 32'd1);
    card_token(3'b101);
    wait_done(20, ok, n);      check("t3_done", 32'(ok), 32'd1);
    check("t3_err", 32'(o_err_code), 32'd3);
    crc = 16'h0000; bad = 0;
    for (int k = 0; k < BB; k++) begin
      b = pat(1, k);
      for (int j = 7; j >= 0; j--) begin
        crc = crc_ref(crc, b[j]);
        if (cap[base + 3 + k * 8 + (7 - j)] !== b[j]) bad++;
      end
    end
    check("t3_data_bits", bad, 0);
    check("t3_crc", 32'(cap_crc(base)), 32'(crc));
    tick();

    // 4: source stops after 10 bytes
    begin_block(2, 10, base);
    wait_oe(1'b1, 50, ok);     check("t4_oe_up", 32'(ok), 32'd1);
    wait_oe(1'b0, 2000, ok);   check("t4_oe_down", 32'(ok), 32'd1);
    wait_done(20, ok, n);      check("t4_done", 32'(ok), 32'd1);
    check("t4_err", 32'(o_err_code), 32'd1);
    check("t4_nbits", cap_n - base, 3 + 80 + 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_in_ready) n++;
    end
    check("t4_no_ready_after", n, 0);

    // 5: no token start bit; extra start while busy is ignored
    begin_block(2, BB, base);
    repeat (200) tick();
    pulse_start();
    check("t5_busy_after_restart", 32'(o_busy), 32'd1);
    wait_oe(1'b0, 20000, ok);  check("t5_oe_down", 32'(ok), 32'd1);
    i_sddat0_in = 1'b1;
    wait_done(200, ok, n);     check("t5_done", 32'(ok), 32'd1);
    check("t5_token_clocks", n, 2 + TT);
    check("t5_err", 32'(o_err_code), 32'd2);
    check("t5_nbits", cap_n - base, NBITS);
    tick();

    // 6: good token, card never leaves busy
    begin_block(0, BB, base);
    wait_oe(1'b1, 50, ok);     check("t6_oe_up", 32'(ok), 32'd1);
    wait_oe(1'b0, 20000, ok);  check("t6_oe_down", 32'(ok), 32'd1);
    card_token(3'b010);
    i_sddat0_in = 1'b0;
    wait_done(400, ok, n);     check("t6_done", 32'(ok), 32'd1);
    check("t6_busy_clocks", n, BT);
    check("t6_err", 32'(o_err_code), 32'd5);
    i_sddat0_in = 1'b1;
    tick();
    check("t6_err_holds", 32'(o_err_code), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
